// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the fetch/data memory-port arbiter:
//   - default address/data widths and starvation threshold
//   - byte-enable width and the all-ones byte-enable used for fetches
//   - FSM state encoding (the owner of the outstanding access lives in it)
//   - owner encoding and a helper mapping an owner to its wait state
// Optional feature macro used by the arbiter: ARB_STARVE_GUARD_EN
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;

  localparam int BE_W = ARB_DATA_W / 8;
  localparam logic [BE_W-1:0] BE_ALL_ONES = {BE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Wait state that records a freshly accepted access for the given owner
  function automatic state_e wait_state(input owner_e owner);
    if (owner == OWN_D) begin
      return WAIT_D;
    end else begin
      return WAIT_I;
    end
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// -----------------------------------------------------------------------------
// arb_starve_ctr
// Counts data grants that were won while a fetch was waiting. Once the count
// reaches STARVE_MAX, force_instr tells the arbiter to hand the next slot to
// the fetch port. Any fetch grant clears the count.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   inc         in   data grant accepted while the fetch port was requesting
//   clr         in   fetch grant accepted
//   force_instr out  threshold reached, fetch must win the next arbitration
// -----------------------------------------------------------------------------
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic force_instr
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Loss counter; saturates at the threshold so it can never wrap back to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign force_instr = (cnt_r == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch port (read only) and the
// load/store data port. One access is outstanding at a time; the owner of that
// access is held in the FSM state and its response is steered back to it.
// A new access may be granted in the same cycle the previous response returns.
// Data has priority over fetch; with ARB_STARVE_GUARD_EN defined, the fetch
// port is forced through after STARVE_MAX consecutive losses.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request      -> i_gnt, i_rvalid, i_rdata
//   d_req/d_we/d_be/d_addr/d_wdata  data request -> d_gnt, d_rvalid, d_rdata
//   m_req/m_we/m_be/m_addr/m_wdata  memory request, accepted on m_ready
//   m_rvalid/m_rdata         memory response (one per accepted access)
//   busy                     an access is outstanding
//   spurious_rsp             sticky: response arrived with nothing outstanding
// Optional feature macro: ARB_STARVE_GUARD_EN
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_be,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic                busy,
  output logic                spurious_rsp
);

  localparam int PBE_W = DATA_W / 8;

  state_e state_r;
  state_e state_next_s;
  owner_e pick_s;
  logic   arb_slot_s;
  logic   accept_s;
  logic   force_instr_s;
  logic   spurious_r;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk         (clk),
    .rst         (rst),
    .inc         (d_gnt && i_req),
    .clr         (i_gnt),
    .force_instr (force_instr_s)
  );
`else
  // Strict data priority; the threshold expression is constant false for any
  // legal STARVE_MAX and only keeps the parameter referenced.
  assign force_instr_s = (STARVE_MAX < 32'sd0);
`endif

  // Arbitration window: idle, or the cycle the outstanding response returns
  always_comb begin
    arb_slot_s = 1'b0;
    case (state_r)
      IDLE:           arb_slot_s = 1'b1;
      WAIT_I, WAIT_D: arb_slot_s = m_rvalid;
      default:        arb_slot_s = 1'b0;
    endcase
  end

  // Data wins unless the starvation guard is pushing a waiting fetch through
  always_comb begin
    if (d_req && !(force_instr_s && i_req)) begin
      pick_s = OWN_D;
    end else begin
      pick_s = OWN_I;
    end
  end

  // Request, grant and response-valid steering; all held low during reset
  always_comb begin
    m_req    = 1'b0;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    if (rst) begin
      m_req    = 1'b0;
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end else begin
      m_req    = arb_slot_s && (i_req || d_req);
      i_gnt    = m_req && m_ready && (pick_s == OWN_I);
      d_gnt    = m_req && m_ready && (pick_s == OWN_D);
      i_rvalid = (state_r == WAIT_I) && m_rvalid;
      d_rvalid = (state_r == WAIT_D) && m_rvalid;
    end
  end

  assign accept_s = i_gnt || d_gnt;

  // Memory request fields follow the currently chosen requester
  always_comb begin
    if (pick_s == OWN_D) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_we    = 1'b0;
      m_be    = {PBE_W{1'b1}};
      m_addr  = i_addr;
      m_wdata = {DATA_W{1'b0}};
    end
  end

  // Only one access is ever in flight, so read data is simply fanned out
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Next state: a new grant wins over the return to idle on a response
  always_comb begin
    state_next_s = state_r;
    if (accept_s) begin
      state_next_s = wait_state(pick_s);
    end else if (m_rvalid && (state_r != IDLE)) begin
      state_next_s = IDLE;
    end else begin
      state_next_s = state_r;
    end
  end

  // State register and sticky spurious-response flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      spurious_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (m_rvalid && (state_r == IDLE)) begin
        spurious_r <= 1'b1;
      end else begin
        spurious_r <= spurious_r;
      end
    end
  end

  assign busy         = (state_r != IDLE);
  assign spurious_rsp = spurious_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req, m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_ready, m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              busy, spurious_rsp;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .spurious_rsp(spurious_rsp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected memory-side fields for a chosen requester
  task chk_mfields(input string tag, input logic dsel);
    chk1({tag, "_m_we"},     m_we,    dsel ? d_we : 1'b0);
    chk32({tag, "_m_be"},    {28'd0, m_be}, dsel ? {28'd0, d_be} : 32'h0000000F);
    chk32({tag, "_m_addr"},  m_addr,  dsel ? d_addr : i_addr);
    chk32({tag, "_m_wdata"}, m_wdata, dsel ? d_wdata : 32'h0);
  endtask

  // ---------------- behavioural reference model ----------------
  int   own;      // 0 = nothing outstanding, 1 = fetch, 2 = data
  int   starve;   // consecutive fetch losses
  bit   spur;
  logic e_mreq, e_ig, e_dg, e_irv, e_drv, e_pd;

  task model_reset();
    own = 0; starve = 0; spur = 1'b0;
  endtask

  task model_eval();
    logic slot;
    slot   = (own == 0) || m_rvalid;
    e_pd   = d_req && !(GUARD && (starve >= STARVE_MAX) && i_req);
    e_mreq = slot && (i_req || d_req);
    e_ig   = e_mreq && m_ready && !e_pd;
    e_dg   = e_mreq && m_ready && e_pd;
    e_irv  = (own == 1) && m_rvalid;
    e_drv  = (own == 2) && m_rvalid;
  endtask

  task model_step();
    if ((own == 0) && m_rvalid) spur = 1'b1;
    if (e_ig) begin
      own = 1; starve = 0;
    end else if (e_dg) begin
      own = 2;
      if (i_req) starve++;
    end else if (m_rvalid) begin
      own = 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic i_req, d_req, d_we, m_ready, m_rvalid;
    logic e_mreq, e_ig, e_dg, e_irv, e_drv, e_busy, e_dsel;
  } vec_t;

  vec_t vt[13];

  task quiet_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
  endtask

  task do_reset();
    @(negedge clk);
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; m_ready = 1'b1; m_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_i_gnt", i_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_i_rvalid", i_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_inputs();
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_spurious", spurious_rsp, 1'b0);
    model_reset();
    @(posedge clk);
  endtask

  initial begin
    int   grants;
    bit   gi, gd, pend;
    bit   is_i[$];
    bit   last_ig, last_dg, mem_busy;
    int   mem_delay;

    rst = 1'b1;
    quiet_inputs();
    i_addr = 32'h0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0; m_rdata = 32'h0;

    //                 in: i d we rdy rv  exp: mreq ig dg irv drv busy dsel
    vt[0]  = 12'b10010_1100000;  // single fetch accepted
    vt[1]  = 12'b00010_0000010;  // waiting
    vt[2]  = 12'b00011_0001010;  // fetch data returned
    vt[3]  = 12'b11110_1010001;  // both request: store wins
    vt[4]  = 12'b10010_0000010;  // fetch waits while store outstanding
    vt[5]  = 12'b10011_1100110;  // store ack + fetch granted, no bubble
    vt[6]  = 12'b00011_0001010;  // fetch data returned
    vt[7]  = 12'b01000_1000001;  // backpressure 1
    vt[8]  = 12'b01000_1000001;  // backpressure 2
    vt[9]  = 12'b01000_1000001;  // backpressure 3
    vt[10] = 12'b01010_1010001;  // accepted on 4th cycle
    vt[11] = 12'b00011_0000110;  // load data returned
    vt[12] = 12'b00001_0000000;  // response with nothing outstanding

    do_reset();

    i_addr = 32'h0000_0100; d_addr = 32'h0000_2000; d_be = 4'h3;
    d_wdata = 32'hDEAD_BEEF; m_rdata = 32'h0050_0093;
    for (int r = 0; r < 13; r++) begin
      string tag;
      tag = $sformatf("vec%0d", r);
      @(negedge clk);
      i_req = vt[r].i_req; d_req = vt[r].d_req; d_we = vt[r].d_we;
      m_ready = vt[r].m_ready; m_rvalid = vt[r].m_rvalid;
      #1;
      chk1({tag, "_m_req"},    m_req,    vt[r].e_mreq);
      chk1({tag, "_i_gnt"},    i_gnt,    vt[r].e_ig);
      chk1({tag, "_d_gnt"},    d_gnt,    vt[r].e_dg);
      chk1({tag, "_i_rvalid"}, i_rvalid, vt[r].e_irv);
      chk1({tag, "_d_rvalid"}, d_rvalid, vt[r].e_drv);
      chk1({tag, "_busy"},     busy,     vt[r].e_busy);
      chk1({tag, "_spurious"}, spurious_rsp, 1'b0);
      if (vt[r].e_mreq) chk_mfields(tag, vt[r].e_dsel);
      if (vt[r].e_irv)  chk32({tag, "_i_rdata"}, i_rdata, 32'h0050_0093);
      if (vt[r].e_drv)  chk32({tag, "_d_rdata"}, d_rdata, 32'h0050_0093);
      @(posedge clk);
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    chk1("spurious_set", spurious_rsp, 1'b1);
    chk1("spurious_busy", busy, 1'b0);
    @(posedge clk);

    // Reset while a load is outstanding, then a late response
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; m_ready = 1'b1;
    #1;
    chk1("rstw_d_gnt", d_gnt, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; m_rvalid = 1'b1;
    #1;
    chk1("rstw_m_req", m_req, 1'b0);
    chk1("rstw_gnt", i_gnt | d_gnt, 1'b0);
    chk1("rstw_d_rvalid", d_rvalid, 1'b0);
    chk1("rstw_i_rvalid", i_rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_inputs();
    #1;
    chk1("rstw_busy", busy, 1'b0);
    chk1("rstw_spurious", spurious_rsp, 1'b0);
    @(posedge clk);
    @(negedge clk);
    m_rvalid = 1'b1;
    #1;
    chk1("late_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk1("late_spurious", spurious_rsp, 1'b1);
    @(posedge clk);

    // Starvation: both ports request continuously, memory answers next cycle
    do_reset();
    pend = 1'b0;
    for (int c = 0; c < 60 && is_i.size() < 10; c++) begin
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; m_ready = 1'b1; m_rvalid = pend;
      #1;
      gi = i_gnt; gd = d_gnt;
      if (gi || gd) is_i.push_back(gi);
      pend = (gi || gd) ? 1'b1 : (m_rvalid ? 1'b0 : pend);
      @(posedge clk);
    end
    grants = is_i.size();
    chk32("starve_grants", grants, 32'd10);
    for (int p = 0; p < is_i.size(); p++) begin
      chk1($sformatf("starve_grant%0d_is_fetch", p), is_i[p], GUARD && ((p % 5) == 4));
    end

    // Randomised traffic against the reference model
    do_reset();
    last_ig = 1'b0; last_dg = 1'b0; mem_busy = 1'b0; mem_delay = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (last_ig) i_req = 1'b0;
      if (last_dg) d_req = 1'b0;
      if (!i_req && ($urandom % 3 == 0)) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (!d_req && ($urandom % 3 == 0)) begin
        d_req = 1'b1; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      m_rvalid = mem_busy && (mem_delay == 0);
      m_rdata  = $urandom;
      m_ready  = ($urandom % 4) != 0;
      #1;
      model_eval();
      chk1("rnd_m_req", m_req, e_mreq);
      chk1("rnd_i_gnt", i_gnt, e_ig);
      chk1("rnd_d_gnt", d_gnt, e_dg);
      chk1("rnd_i_rvalid", i_rvalid, e_irv);
      chk1("rnd_d_rvalid", d_rvalid, e_drv);
      chk1("rnd_busy", busy, own != 0);
      chk1("rnd_spurious", spurious_rsp, spur);
      if (e_mreq) chk_mfields("rnd", e_pd);
      if (e_irv) chk32("rnd_i_rdata", i_rdata, m_rdata);
      if (e_drv) chk32("rnd_d_rdata", d_rdata, m_rdata);
      @(posedge clk);
      model_step();
      if (m_rvalid) mem_busy = 1'b0;
      else if (mem_busy) mem_delay--;
      if (e_ig || e_dg) begin
        mem_busy = 1'b1; mem_delay = $urandom_range(2, 0);
      end
      last_ig = e_ig; last_dg = e_dg;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
